booth_pp_accumulator: RTL and testbench

Sequential consumer of radix-4 Booth partial products. It takes one partial product per cycle, together with its 1's-complement correction bit, over a valid/ready handshake. Each beat is sign-extended, corrected, weighted by 4^index and summed into a 2·INPUT_SIZE-bit product, which is presented on an output valid/ready handshake. It sits between the partial-product generator and the multiplier result register, replacing a combinational adder tree in area-constrained multiplier configurations.

---
 rtl/booth_pp_accumulator.sv | 105 ++++++++++
 tb/tb_booth_pp_accumulator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator of radix-4 Booth partial products, one beat per cycle.
// Define BOOTH_ACC_COUNT_CHECK_EN to enable the sticky beat-count overflow flag on err.
module booth_pp_accumulator #(
  parameter int INPUT_SIZE  = 16,
  parameter int PP_SIZE     = INPUT_SIZE + 2,
  parameter int OUTPUT_SIZE = 2 * INPUT_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PP_SIZE-1:0]     pp_in,
  input  logic                   pp_sign_low,
  input  logic                   pp_last,
  input  logic                   pp_valid,
  output logic                   pp_ready,
  output logic [OUTPUT_SIZE-1:0] prod,
  output logic                   prod_valid,
  input  logic                   prod_ready,
  output logic                   err
);

  localparam int IDX_W = $clog2(INPUT_SIZE / 2 + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [OUTPUT_SIZE-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   accept;
  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W:0]         shamt;
  logic [OUTPUT_SIZE-1:0] term_base;
  logic [OUTPUT_SIZE-1:0] term;

  assign pp_ready   = (state_q != DONE);
  assign prod_valid = (state_q == DONE);
  assign prod       = acc_q;
  assign accept     = pp_valid & pp_ready;

  // The first beat of a multiplication always has index 0, whatever idx_q holds.
  assign cur_idx   = (state_q == IDLE) ? '0 : idx_q;
  assign shamt     = {cur_idx, 1'b0};
  assign term_base = {{(OUTPUT_SIZE - PP_SIZE){pp_in[PP_SIZE-1]}}, pp_in}
                     + OUTPUT_SIZE'(pp_sign_low);
  assign term      = (32'(shamt) >= 32'(OUTPUT_SIZE)) ? '0 : (term_base << shamt);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = term;
          idx_d   = IDX_W'(1);
          state_d = pp_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = acc_q + term;
          if (idx_q != '1) idx_d = idx_q + IDX_W'(1);
          if (pp_last) state_d = DONE;
        end
      end
      DONE: begin
        if (prod_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

`ifdef BOOTH_ACC_COUNT_CHECK_EN
  localparam int ERR_IDX = INPUT_SIZE / 2 + 1;

  logic err_q, err_d;

  assign err_d = err_q | (accept && (32'(cur_idx) >= 32'(ERR_IDX)));
  assign err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed self-checking bench for booth_pp_accumulator (INPUT_SIZE=16).
// Expected products are hand-computed sums of sign-extended, 4^i-weighted beats.
module tb_booth_pp_accumulator;

  logic        clk;
  logic        rst;
  logic [17:0] pp_in;
  logic        pp_sign_low;
  logic        pp_last;
  logic        pp_valid;
  logic        pp_ready;
  logic [31:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic        err;

  int checks_q   = 0;
  int failures_q = 0;

  booth_pp_accumulator #(.INPUT_SIZE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pp_in       (pp_in),
    .pp_sign_low (pp_sign_low),
    .pp_last     (pp_last),
    .pp_valid    (pp_valid),
    .pp_ready    (pp_ready),
    .prod        (prod),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_q++;
    if (obs !== exp) begin
      failures_q++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [17:0] pp, input logic sl, input logic last);
    int n;
    n = 0;
    pp_in       = pp;
    pp_sign_low = sl;
    pp_last     = last;
    pp_valid    = 1'b1;
    while (!pp_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(pp_ready), 32'd1);
    tick();
    pp_valid = 1'b0;
    pp_last  = 1'b0;
  endtask

  task automatic consume();
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pp_in = '0; pp_sign_low = 1'b0; pp_last = 1'b0;
    pp_valid = 1'b0; prod_ready = 1'b0;
    tick();
    tick();

    check("rst_pp_ready",   32'(pp_ready),   32'd1);
    check("rst_prod_valid", 32'(prod_valid), 32'd0);
    check("rst_prod",       prod,            32'd0);
    check("rst_err",        32'(err),        32'd0);
    rst = 1'b0;
    tick();

    // Single positive beat; prod_valid must rise right after acceptance.
    check("single_pre_valid", 32'(prod_valid), 32'd0);
    send(18'h00005, 1'b0, 1'b1);
    check("single_valid", 32'(prod_valid), 32'd1);
    check("single_prod",  prod,            32'h00000005);
    check("done_ready",   32'(pp_ready),   32'd0);
    consume();
    check("idle_after_consume", 32'(prod_valid), 32'd0);

    // Negated single beat: 1's complement plus correction gives -5.
    send(18'h3FFFA, 1'b1, 1'b1);
    check("neg_prod", prod, 32'hFFFFFFFB);
    consume();

    // Two beats: 5 + 3*4.
    send(18'h00005, 1'b0, 1'b0);
    check("two_mid_valid", 32'(prod_valid), 32'd0);
    send(18'h00003, 1'b0, 1'b1);
    check("two_prod", prod, 32'h00000011);
    consume();

    // Three beats with bubbles and correction bits: -1 + 4 + 16 = 19.
    send(18'h3FFFE, 1'b1, 1'b0);
    tick();
    tick();
    check("bubble_ready", 32'(pp_ready),   32'd1);
    check("bubble_valid", 32'(prod_valid), 32'd0);
    check("bubble_acc",   prod,            32'hFFFFFFFF);
    send(18'h00001, 1'b0, 1'b0);
    send(18'h00000, 1'b1, 1'b1);
    check("mixed_prod", prod, 32'h00000013);
    consume();

    // Back-pressure: next beat waits while DONE is held.
    send(18'h00009, 1'b0, 1'b1);
    pp_in = 18'h00002; pp_sign_low = 1'b0; pp_last = 1'b1; pp_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_ready_%0d", k), 32'(pp_ready),   32'd0);
      check($sformatf("bp_prod_%0d", k),  prod,            32'h00000009);
      check($sformatf("bp_valid_%0d", k), 32'(prod_valid), 32'd1);
    end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    check("bp_release_ready", 32'(pp_ready),   32'd1);
    check("bp_release_valid", 32'(prod_valid), 32'd0);
    tick();
    pp_valid = 1'b0; pp_last = 1'b0;
    check("bp_pending_valid", 32'(prod_valid), 32'd1);
    check("bp_pending_prod",  prod,            32'h00000002);
    consume();

    // Sign extension at the top of the partial-product range.
    send(18'h1FFFF, 1'b0, 1'b1);
    check("max_pos_prod", prod, 32'h0001FFFF);
    consume();
    send(18'h20000, 1'b0, 1'b1);
    check("max_neg_prod", prod, 32'hFFFE0000);
    consume();

    // Eight beats, only the last (index 7) is -1: -(1<<14).
    for (int k = 0; k < 7; k++) send(18'h00000, 1'b0, 1'b0);
    send(18'h3FFFF, 1'b0, 1'b1);
    check("eight_prod", prod, 32'hFFFFC000);
    consume();

    // Asynchronous reset after 3 of 9 beats discards the partial sum.
    for (int k = 0; k < 3; k++) send(18'h00001, 1'b0, 1'b0);
    check("pre_rst_acc", prod, 32'h00000015);
    rst = 1'b1;
    #1;
    check("midrst_prod",     prod,            32'd0);
    check("midrst_valid",    32'(prod_valid), 32'd0);
    check("midrst_ready",    32'(pp_ready),   32'd1);
    check("midrst_err",      32'(err),        32'd0);
    tick();
    rst = 1'b0;
    tick();
    send(18'h00007, 1'b0, 1'b1);
    check("post_rst_prod", prod, 32'h00000007);
    consume();

    // Ten beats of 1: sum of 4^0..4^9; index 9 overflows the beat count.
    for (int k = 0; k < 9; k++) send(18'h00001, 1'b0, 1'b0);
    check("cnt_err_before", 32'(err), 32'd0);
    send(18'h00001, 1'b0, 1'b1);
    check("cnt_prod", prod, 32'h00055555);
`ifdef BOOTH_ACC_COUNT_CHECK_EN
    check("cnt_err_set", 32'(err), 32'd1);
    consume();
    check("cnt_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    check("cnt_err_cleared", 32'(err), 32'd0);
    rst = 1'b0;
`else
    check("cnt_err_off", 32'(err), 32'd0);
    consume();
    check("cnt_err_off_idle", 32'(err), 32'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
